uart_tx_fifo: RTL and testbench

Byte FIFO sitting directly upstream of the uart transmitter. It accepts bytes from a producer with a valid/ready push interface, buffers up to DEPTH of them, and drives the uart transmit inputs: uart_din, a one-cycle uart_wr_en pulse, and uart_tx_busy monitoring. Producers can burst bytes without tracking per-byte serial timing.

---
 rtl/uart_tx_fifo.sv | 136 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a uart transmitter.
//
// Producers push bytes through a valid/ready interface. Buffered bytes are
// handed to the uart one at a time as a registered uart_din plus a one-cycle
// uart_wr_en strobe, paced by uart_tx_busy.
//
// Ports:
//   clk_50m       system clock, shared with the uart
//   rst           asynchronous active-high reset
//   wr_data       byte to enqueue
//   wr_valid      push request
//   wr_ready      !full; push accepted when wr_valid && wr_ready
//   level         occupancy, 0..DEPTH
//   empty, full   level == 0 / level == DEPTH
//   overflow      sticky flag: push attempted while full
//   ovf_clr       clears overflow (a simultaneous set wins)
//   uart_din      byte presented to the uart (registered)
//   uart_wr_en    one-cycle transmit strobe (registered)
//   uart_tx_busy  uart busy, high from the cycle after wr_en is sampled
module uart_tx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_50m,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [ADDR_W:0]   level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        uart_din,
  output logic              uart_wr_en,
  input  logic              uart_tx_busy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StGuard = 2'd2;
  localparam logic [1:0] StWait  = 2'd3;

  localparam logic [ADDR_W:0]   LevelFull = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   LevelOne  = 1;
  localparam logic [ADDR_W-1:0] PtrOne    = 1;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              overflow_q, overflow_d;
  logic [1:0]        state_q, state_d;
  logic [7:0]        uart_din_q, uart_din_d;
  logic              uart_wr_en_q, uart_wr_en_d;
  logic              push, pop;

  assign full       = (level_q == LevelFull);
  assign empty      = (level_q == '0);
  assign wr_ready   = !full;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign uart_din   = uart_din_q;
  assign uart_wr_en = uart_wr_en_q;

  // Acceptance looks only at full from the start of the cycle; a pop on the
  // same edge does not make room for this push.
  assign push = wr_valid && !full;
  assign pop  = (state_q == StIdle) && !empty && !uart_tx_busy;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LevelOne;
      2'b01:   level_d = level_q - LevelOne;
      default: level_d = level_q;
    endcase

    // Set has priority over clear.
    overflow_d = overflow_q;
    if (ovf_clr)          overflow_d = 1'b0;
    if (wr_valid && full) overflow_d = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    uart_din_d   = uart_din_q;
    uart_wr_en_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (pop) begin
          uart_din_d   = mem_q[rd_ptr_q];
          uart_wr_en_d = 1'b1;
          state_d      = StIssue;
        end
      end
      StIssue: state_d = StGuard;
      // The uart raises busy one cycle after sampling wr_en, so busy is not
      // trustworthy until WAIT.
      StGuard: state_d = StWait;
      StWait: begin
        if (!uart_tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Storage is not reset.
  always_ff @(posedge clk_50m) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      state_q      <= StIdle;
      uart_din_q   <= 8'h00;
      uart_wr_en_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      state_q      <= state_d;
      uart_din_q   <= uart_din_d;
      uart_wr_en_q <= uart_wr_en_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. A small uart model raises busy for a fixed frame
// after sampling wr_en; hold_busy forces busy high. Every accepted push queues
// its byte; a monitor pops and compares on each uart_wr_en pulse.
module tb_uart_tx_fifo;

  localparam int unsigned Frame = 12;

  logic       clk_50m = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] level;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       ovf_clr;
  logic [7:0] uart_din;
  logic       uart_wr_en;
  logic       uart_tx_busy;

  logic       hold_busy    = 1'b0;
  logic [4:0] busy_cnt     = '0;
  logic       busy_at_edge = 1'b0;
  logic       wr_en_prev   = 1'b0;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  logic [7:0] sb_q[$];

  uart_tx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk_50m     (clk_50m),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .level       (level),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .uart_din    (uart_din),
    .uart_wr_en  (uart_wr_en),
    .uart_tx_busy(uart_tx_busy)
  );

  always #10 clk_50m = ~clk_50m;

  // uart model: frames are not aborted by the FIFO's reset.
  assign uart_tx_busy = (busy_cnt != '0) || hold_busy;
  always @(posedge clk_50m) begin
    busy_at_edge <= uart_tx_busy;
    if (uart_wr_en)           busy_cnt <= 5'(Frame);
    else if (busy_cnt != '0)  busy_cnt <= busy_cnt - 5'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each issued byte against the scoreboard.
  always @(negedge clk_50m) begin
    if (!rst && uart_wr_en) begin
      pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got uart_din 0x%0h expected no pulse", uart_din);
      end else begin
        chk("uart_din_order", {24'h0, uart_din}, {24'h0, sb_q.pop_front()});
      end
      chk("issue_while_busy", {31'h0, busy_at_edge}, 32'h0);
      chk("wr_en_one_cycle", {31'h0, wr_en_prev}, 32'h0);
    end
    wr_en_prev <= uart_wr_en;
  end

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic acc);
    wr_data  = b;
    wr_valid = 1'b1;
    chk("wr_ready", {31'h0, wr_ready}, {31'h0, acc});
    if (acc) sb_q.push_back(b);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (sb_q.size() == 0 && empty && busy_cnt == '0 && !hold_busy) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: got %0d bytes pending expected 0", sb_q.size());
    end
    repeat (4) tick();
  endtask

  initial begin
    int p0;
    bit seen;
    rst      = 1'b1;
    wr_data  = 8'h00;
    wr_valid = 1'b0;
    ovf_clr  = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_level", {27'h0, level}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_overflow", {31'h0, overflow}, 32'd0);
    chk("rst_din", {24'h0, uart_din}, 32'h00);
    chk("rst_wr_en", {31'h0, uart_wr_en}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // 1: single byte latency
    push(8'hA5, 1'b1);
    chk("t1_wr_en_k", {31'h0, uart_wr_en}, 32'd0);
    chk("t1_level_k", {27'h0, level}, 32'd1);
    tick();
    chk("t1_wr_en_k1", {31'h0, uart_wr_en}, 32'd1);
    chk("t1_din", {24'h0, uart_din}, 32'hA5);
    chk("t1_level_k1", {27'h0, level}, 32'd0);
    chk("t1_empty", {31'h0, empty}, 32'd1);
    tick();
    chk("t1_wr_en_k2", {31'h0, uart_wr_en}, 32'd0);
    wait_drain();

    // 2: burst 0x00..0x0F while uart held busy, then drain in order
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
    chk("t2_full", {31'h0, full}, 32'd1);
    chk("t2_level", {27'h0, level}, 32'd16);
    hold_busy = 1'b0;
    wait_drain();
    chk("t2_overflow", {31'h0, overflow}, 32'd0);

    // 3: overflow on full, clear, set-wins, 0x77 never issued
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) push(8'h30 + 8'(i), 1'b1);
    push(8'h77, 1'b0);
    chk("t3_overflow_set", {31'h0, overflow}, 32'd1);
    chk("t3_level", {27'h0, level}, 32'd16);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t3_overflow_clr", {31'h0, overflow}, 32'd0);
    ovf_clr = 1'b1;
    push(8'h78, 1'b0);
    ovf_clr = 1'b0;
    chk("t3_set_wins", {31'h0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    hold_busy = 1'b0;
    wait_drain();

    // 4: simultaneous push and pop at level 1
    hold_busy = 1'b1;
    push(8'h11, 1'b1);
    hold_busy = 1'b0;
    push(8'h22, 1'b1);
    chk("t4_level", {27'h0, level}, 32'd1);
    chk("t4_din", {24'h0, uart_din}, 32'h11);
    chk("t4_wr_en", {31'h0, uart_wr_en}, 32'd1);
    wait_drain();

    // 5: busy forced high for 100 cycles with 3 bytes queued
    hold_busy = 1'b1;
    push(8'h51, 1'b1);
    push(8'h52, 1'b1);
    push(8'h53, 1'b1);
    p0 = pulses;
    repeat (100) tick();
    chk("t5_no_issue_held", pulses - p0, 32'd0);
    chk("t5_level_held", {27'h0, level}, 32'd3);
    hold_busy = 1'b0;
    wait_drain();
    chk("t5_three_pulses", pulses - p0, 32'd3);

    // 6: reset during WAIT with 5 bytes queued
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i), 1'b1);
    hold_busy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uart_wr_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t6_first_pulse", {31'h0, seen}, 32'd1);
    repeat (4) tick();
    chk("t6_level_wait", {27'h0, level}, 32'd5);
    rst = 1'b1;
    #1;
    chk("t6_rst_wr_en", {31'h0, uart_wr_en}, 32'd0);
    chk("t6_rst_level", {27'h0, level}, 32'd0);
    chk("t6_rst_empty", {31'h0, empty}, 32'd1);
    sb_q.delete();
    tick();
    tick();
    rst = 1'b0;
    p0 = pulses;
    repeat (30) tick();
    chk("t6_no_pulse_after_rst", pulses - p0, 32'd0);
    push(8'h99, 1'b1);
    wait_drain();
    chk("t6_new_push_issued", pulses - p0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
